// File: rtl/fc_neuron_stream_pkg.sv
// ---------------------------------------------------------------------------
// fc_neuron_stream_pkg
//   Shared types and width helpers for the streaming fully-connected neuron.
//   - state_t         : control FSM states
//   - acc_width()     : accumulator / result width for a given element width
//                       and fan-in
//   - lane_sum_width(): width of one beat's lane dot product
//   - lane_index()    : flat weight index of lane `lane` in beat `beat`
// ---------------------------------------------------------------------------
package fc_neuron_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // n_in products of (-2^(width-1))^2 need 2*width-1+clog2(n_in) magnitude
    // bits; one extra sign bit plus one bit of headroom absorbs the bias.
    function automatic int acc_width(input int width, input int n_in);
        return 2 * width + $clog2(n_in) + 1;
    endfunction

    function automatic int lane_sum_width(input int width, input int lanes);
        return 2 * width + $clog2(lanes);
    endfunction

    function automatic int lane_index(input int beat, input int lane, input int lanes);
        return beat * lanes + lane;
    endfunction

endpackage

// File: rtl/fc_neuron_stream_if.sv
// ---------------------------------------------------------------------------
// fc_neuron_stream_if
//   Input beat stream and result port of the neuron.
//   Input side : in_valid / in_ready handshake, x[LANES] signed beat, flush
//   Output side: out_valid / out_ready handshake, z signed result
//   master modport: the upstream/downstream environment
//   slave  modport: the neuron
// ---------------------------------------------------------------------------
interface fc_neuron_stream_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int ACC_W = 20
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x [LANES];
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] z;

    modport master (
        output in_valid, x, flush, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, x, flush, out_ready,
        output in_ready, out_valid, z
    );
endinterface

// File: rtl/fc_neuron_stream_lane_dot.sv
// ---------------------------------------------------------------------------
// fc_neuron_stream_lane_dot
//   Combinational dot product of one beat: LANES signed multipliers feeding a
//   balanced adder tree.
//   i_x[LANES]  : signed input elements of the beat
//   i_w[LANES]  : signed weights selected for the beat
//   o_sum       : signed sum, 2*WIDTH+clog2(LANES) bits, never overflows
// ---------------------------------------------------------------------------
module fc_neuron_stream_lane_dot
    import fc_neuron_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic signed [WIDTH-1:0]                          i_x [LANES],
    input  logic signed [WIDTH-1:0]                          i_w [LANES],
    output logic signed [lane_sum_width(WIDTH, LANES)-1:0]   o_sum
);
    localparam int PROD_W = 2 * WIDTH;
    localparam int SUM_W  = lane_sum_width(WIDTH, LANES);
    // Tree is built over the next power of two; unused leaves are zero.
    localparam int NP     = 1 << $clog2(LANES);

    // Heap layout: leaves at [NP-1 .. 2*NP-2], node i sums children 2i+1, 2i+2.
    logic signed [SUM_W-1:0] w_node [2*NP-1];

    always_comb begin
        for (int i = 0; i < 2 * NP - 1; i++) begin
            w_node[i] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            w_node[NP-1+l] = SUM_W'(PROD_W'(i_x[l]) * PROD_W'(i_w[l]));
        end
        for (int i = NP - 2; i >= 0; i--) begin
            w_node[i] = w_node[2*i+1] + w_node[2*i+2];
        end
    end

    assign o_sum = w_node[0];

endmodule

// File: rtl/fc_neuron_stream.sv
// ---------------------------------------------------------------------------
// fc_neuron_stream
//   Time-multiplexed fully-connected neuron. Consumes an IN-element signed
//   vector as IN/LANES beats of LANES elements, accumulates x*w products on
//   top of BIAS, optionally applies ReLU and presents one result.
//   clk   : clock
//   rst   : asynchronous reset, active-high
//   i_w   : signed weights [IN], held static while a vector is in flight
//   bus   : slave side of fc_neuron_stream_if (beat in, result out, flush)
//   Pipeline: accept edge registers the beat dot product (p1), next edge
//   adds it into the accumulator (p2), next edge registers z.
// ---------------------------------------------------------------------------
module fc_neuron_stream
    import fc_neuron_stream_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int IN      = 128,
    parameter int LANES   = 4,
    parameter int RELU_EN = 1,
    parameter int BIAS    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] i_w [IN],
    fc_neuron_stream_if.slave       bus
);
    localparam int ACC_W = acc_width(WIDTH, IN);
    localparam int SUM_W = lane_sum_width(WIDTH, LANES);
    localparam int BEATS = IN / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;

    localparam logic        [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic signed [ACC_W-1:0] BIAS_INIT = ACC_W'(BIAS);

    generate
        if (IN % LANES != 0) begin : g_bad_lanes
            $error("fc_neuron_stream: IN must be a multiple of LANES");
        end
    endgenerate

    function automatic logic signed [ACC_W-1:0] f_relu(input logic signed [ACC_W-1:0] a);
        if (RELU_EN != 0 && a[ACC_W-1]) begin
            return '0;
        end
        return a;
    endfunction

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_beat_cnt;
    logic                    r_drain_cnt;
    logic                    r_in_ready;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_flush;
    logic                    w_out_hs;

    logic signed [WIDTH-1:0] w_wsel [LANES];
    logic signed [SUM_W-1:0] w_lane_sum;

    logic signed [SUM_W-1:0] r_sum_p1;
    logic                    r_vld_p1;
    logic                    r_last_p1;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_vld_p2;
    logic signed [ACC_W-1:0] r_z;
    logic                    r_out_valid;

    // Weight mux: the current beat selects its LANES-wide weight window.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_wsel[l] = i_w[IDX_W'(lane_index(int'(r_beat_cnt), l, LANES))];
        end
    end

    fc_neuron_stream_lane_dot #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_lane_dot (
        .i_x   (bus.x),
        .i_w   (w_wsel),
        .o_sum (w_lane_sum)
    );

    // Next-state and handshake decode. A flushed cycle never accepts a beat,
    // and flush is ignored in OUT so a finished result cannot be lost.
    always_comb begin
        w_next   = r_state;
        w_flush  = bus.flush && (r_state != OUT);
        w_accept = bus.in_valid && r_in_ready && !bus.flush;
        w_last   = (r_beat_cnt == LAST_BEAT);
        w_out_hs = r_out_valid && bus.out_ready;

        case (r_state)
            IDLE, ACC: begin
                if (w_accept) begin
                    w_next = w_last ? DRAIN : ACC;
                end
            end
            DRAIN: begin
                if (r_drain_cnt) begin
                    w_next = OUT;
                end
            end
            OUT: begin
                if (w_out_hs) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase

        if (w_flush) begin
            w_next = IDLE;
        end
    end

    // in_ready is registered from the next state so it stays low through
    // reset and rises on the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_drain_cnt <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == IDLE) || (w_next == ACC);

            if (w_flush || w_out_hs) begin
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + CNT_W'(1);
            end

            r_drain_cnt <= (r_state == DRAIN) ? !r_drain_cnt : 1'b0;
        end
    end

    // ---- stage 1: register the beat dot product on the accepting edge ----
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sum_p1 <= w_lane_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else begin
            r_vld_p1  <= w_accept;
            r_last_p1 <= w_accept && w_last;
        end
    end

    // ---- stage 2: accumulate; bias is reloaded on flush and on handshake ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= BIAS_INIT;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1 && r_last_p1 && !w_flush;
            if (w_flush || w_out_hs) begin
                r_acc <= BIAS_INIT;
            end else if (r_vld_p1) begin
                r_acc <= r_acc + ACC_W'(r_sum_p1);
            end
        end
    end

    // ---- stage 3: activation and result hold ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z         <= '0;
            r_out_valid <= 1'b0;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end else if (r_vld_p2 && !w_flush) begin
            r_z         <= f_relu(r_acc);
            r_out_valid <= 1'b1;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.z         = r_z;

endmodule

// File: tb/tb_fc_neuron_stream.sv
// ---------------------------------------------------------------------------
// tb_fc_neuron_stream
//   Three neurons (WIDTH=8, IN=8, LANES=4) share one stimulus stream:
//     dut0: RELU_EN=1 BIAS=0   dut1: RELU_EN=0 BIAS=0   dut2: RELU_EN=1 BIAS=-5
//   Expected results and their due cycle are queued when the last beat of a
//   vector is accepted and compared when each neuron presents its result.
// ---------------------------------------------------------------------------
module tb_fc_neuron_stream;
    import fc_neuron_stream_pkg::*;

    localparam int WIDTH = 8;
    localparam int IN    = 8;
    localparam int LANES = 4;
    localparam int BEATS = IN / LANES;
    localparam int ACC_W = acc_width(WIDTH, IN);
    localparam int NDUT  = 3;
    localparam int BIAS_T [NDUT] = '{0, 0, -5};
    localparam int RELU_T [NDUT] = '{1, 0, 1};

    logic clk;
    logic rst;
    logic tb_in_valid;
    logic tb_flush;
    logic tb_out_ready;
    logic signed [WIDTH-1:0] tb_x     [LANES];
    logic signed [WIDTH-1:0] tb_w     [IN];
    logic signed [WIDTH-1:0] tb_vec_x [IN];

    logic [NDUT-1:0]         rdy;
    logic [NDUT-1:0]         ov;
    logic signed [ACC_W-1:0] zo [NDUT];

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    longint exp_q [NDUT][$];
    int     due_q [NDUT][$];
    bit     seen  [NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc_neuron_stream_if #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W)) if0 (), if1 (), if2 ();

    assign if0.in_valid = tb_in_valid;
    assign if0.flush = tb_flush;
    assign if0.out_ready = tb_out_ready;
    assign if0.x = tb_x;
    assign if1.in_valid = tb_in_valid;
    assign if1.flush = tb_flush;
    assign if1.out_ready = tb_out_ready;
    assign if1.x = tb_x;
    assign if2.in_valid = tb_in_valid;
    assign if2.flush = tb_flush;
    assign if2.out_ready = tb_out_ready;
    assign if2.x = tb_x;

    assign rdy[0] = if0.in_ready;
    assign rdy[1] = if1.in_ready;
    assign rdy[2] = if2.in_ready;
    assign ov[0]  = if0.out_valid;
    assign ov[1]  = if1.out_valid;
    assign ov[2]  = if2.out_valid;
    assign zo[0]  = if0.z;
    assign zo[1]  = if1.z;
    assign zo[2]  = if2.z;

    fc_neuron_stream #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU_EN(1), .BIAS(0)) dut0 (
        .clk (clk), .rst (rst), .i_w (tb_w), .bus (if0.slave)
    );
    fc_neuron_stream #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU_EN(0), .BIAS(0)) dut1 (
        .clk (clk), .rst (rst), .i_w (tb_w), .bus (if1.slave)
    );
    fc_neuron_stream #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU_EN(1), .BIAS(-5)) dut2 (
        .clk (clk), .rst (rst), .i_w (tb_w), .bus (if2.slave)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint model(input int d);
        longint s = 0;
        for (int i = 0; i < IN; i++) begin
            s += longint'(tb_vec_x[i]) * longint'(tb_w[i]);
        end
        s += BIAS_T[d];
        if (RELU_T[d] != 0 && s < 0) s = 0;
        return s;
    endfunction

    task automatic fill(input int xv, input int wv);
        for (int i = 0; i < IN; i++) begin
            tb_vec_x[i] = WIDTH'(xv);
            tb_w[i]     = WIDTH'(wv);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < IN; i++) begin
            tb_vec_x[i] = WIDTH'($urandom_range(0, 255));
            tb_w[i]     = WIDTH'($urandom_range(0, 255));
        end
    endtask

    // Offer nb beats of tb_vec_x with `gap` idle cycles between them; when
    // push is set the vector is complete and its results are scoreboarded.
    task automatic send_beats(input int nb, input int gap, input bit push);
        int n;
        for (int b = 0; b < nb; b++) begin
            if (b > 0) begin
                tb_in_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
            for (int l = 0; l < LANES; l++) tb_x[l] = tb_vec_x[b*LANES+l];
            tb_in_valid = 1'b1;
            n = 0;
            while (!rdy[0] && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) check("in_ready_timeout", rdy[0], 1);
            @(posedge clk); #1;
        end
        tb_in_valid = 1'b0;
        if (push) begin
            for (int d = 0; d < NDUT; d++) begin
                exp_q[d].push_back(model(d));
                due_q[d].push_back(cyc + 2);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    endtask

    // Result monitor: latency on first sight, value and in_ready every cycle
    // while valid (covers the hold under back-pressure), pop on handshake.
    initial begin
        for (int d = 0; d < NDUT; d++) seen[d] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int d = 0; d < NDUT; d++) seen[d] = 1'b0;
            end else begin
                for (int d = 0; d < NDUT; d++) begin
                    if (ov[d]) begin
                        if (exp_q[d].size() == 0) begin
                            check($sformatf("spurious_out_valid%0d", d), ov[d], 0);
                        end else begin
                            if (!seen[d]) begin
                                check($sformatf("latency%0d", d), cyc, due_q[d][0]);
                                seen[d] = 1'b1;
                            end
                            check($sformatf("z%0d", d), zo[d], exp_q[d][0]);
                            check($sformatf("in_ready_in_out%0d", d), rdy[d], 0);
                            if (tb_out_ready) begin
                                void'(exp_q[d].pop_front());
                                void'(due_q[d].pop_front());
                                seen[d] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst          = 1'b1;
        tb_in_valid  = 1'b0;
        tb_flush     = 1'b0;
        tb_out_ready = 1'b1;
        for (int l = 0; l < LANES; l++) tb_x[l] = '0;
        fill(0, 0);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_in_ready%0d", d), rdy[d], 0);
            check($sformatf("rst_out_valid%0d", d), ov[d], 0);
            check($sformatf("rst_z%0d", d), zo[d], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", rdy[0], 1);

        // Ones, back-to-back beats
        fill(1, 1);
        send_beats(BEATS, 0, 1);
        drain();

        // Most negative products, ReLU vs pass-through; then most positive,
        // issued back-to-back at the minimum period
        fill(-128, 127);
        send_beats(BEATS, 0, 1);
        fill(-128, -128);
        send_beats(BEATS, 0, 1);
        drain();

        // Idle bubbles between beats
        fill(1, 1);
        send_beats(BEATS, 3, 1);
        drain();

        // Zero products: only the bias remains
        fill(0, 5);
        send_beats(BEATS, 0, 1);
        drain();

        // Back-pressure: hold out_ready low for 5 cycles after valid
        tb_out_ready = 1'b0;
        fill(7, -3);
        tb_vec_x[5] = 8'sd100;
        send_beats(BEATS, 0, 1);
        n = 0;
        while (!ov[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_out_valid", ov[0], 1);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_out_valid", ov[0], 1);
        end
        tb_out_ready = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_hs", rdy[0], 1);
        check("out_valid_after_hs", ov[0], 0);
        drain();

        // Reset after beat 0 discards the partial vector
        fill(9, 9);
        send_beats(1, 0, 0);
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("midrst_out_valid%0d", d), ov[d], 0);
            check($sformatf("midrst_z%0d", d), zo[d], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        fill(2, 3);
        send_beats(BEATS, 0, 1);
        drain();

        // Flush while beat 1 is offered
        fill(4, -3);
        send_beats(1, 0, 0);
        for (int l = 0; l < LANES; l++) tb_x[l] = tb_vec_x[LANES+l];
        tb_in_valid = 1'b1;
        tb_flush    = 1'b1;
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
        tb_flush    = 1'b0;
        check("in_ready_after_flush", rdy[0], 1);
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("no_out_valid_after_flush", ov[0], 0);
        fill(3, 5);
        send_beats(BEATS, 0, 1);
        drain();

        // Random vectors with random bubbles
        for (int k = 0; k < 4; k++) begin
            fill_random();
            send_beats(BEATS, $urandom_range(0, 2), 1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
